// File: rtl/ras_pkg.sv
// Shared types for the return-address-stack sequencer and the stack itself.
// Request codes match the predictor's 2-bit request type field.
package ras_pkg;

    localparam int RAS_ADDR_W = 64;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'b00,
        REQ_CALL  = 2'b01,
        REQ_RET   = 2'b10,
        REQ_CORET = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CORET_PUSH = 2'd1,
        DRAIN      = 2'd2
    } state_e;

endpackage

// File: rtl/ras.sv
// Single-ported return address stack; push wins over pop, overflow/underflow ops are ignored.
// Top/empty/full show the stack as it will be after this cycle's op, so back-to-back requests see it.
module ras
    import ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ras_push_i,
    input  logic              ras_pop_i,
    input  logic [ADDR_W-1:0] ras_addr_i,
    output logic [ADDR_W-1:0] ras_addr_o,
    output logic              ras_empty_o,
    output logic              ras_full_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  sp;
    logic [CNT_W-1:0]  sp_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_push = ras_push_i & (sp != FULL);
    assign do_pop  = ras_pop_i & ~ras_push_i & (sp != '0);

    always_comb begin
        sp_nxt = sp;
        if (do_push)
            sp_nxt = sp + CNT_W'(1);
        else if (do_pop)
            sp_nxt = sp - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sp <= '0;
        else
            sp <= sp_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem[IDX_W'(sp)] <= ras_addr_i;
    end

    assign ras_addr_o  = (sp_nxt == '0) ? '0 :
                         do_push        ? ras_addr_i :
                                          mem[IDX_W'(sp_nxt - CNT_W'(1))];
    assign ras_empty_o = (sp_nxt == '0);
    assign ras_full_o  = (sp_nxt == FULL);

endmodule

// File: rtl/ras_ctrl.sv
// Sequences CALL/RET/CORET into single push/pop pulses one cycle after accept; CORET takes two cycles.
// Flush drains the stack with one pop per cycle; requests stall (ready low) outside IDLE or during flush.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_type_i,
    input  logic [ADDR_W-1:0] req_link_i,
    input  logic              flush_i,
    output logic              pred_valid_o,
    output logic [ADDR_W-1:0] pred_addr_o,
    output logic              ras_push_o,
    output logic              ras_pop_o,
    output logic [ADDR_W-1:0] ras_addr_o,
    input  logic [ADDR_W-1:0] ras_top_i,
    input  logic              ras_empty_i,
    input  logic              ras_full_i,
    output logic [CNT_W-1:0]  depth_o,
    output logic              ovf_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_e            state;
    logic [CNT_W-1:0]  depth_q;
    logic [ADDR_W-1:0] link_q;
    logic              accept;
    logic              is_empty;
    logic              is_full;

    assign req_ready_o = (state == IDLE) & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign busy_o      = (state != IDLE);
    assign depth_o     = depth_q;
    assign is_empty    = (depth_q == '0);
    assign is_full     = (depth_q == FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            depth_q      <= '0;
            link_q       <= '0;
            pred_valid_o <= 1'b0;
            pred_addr_o  <= '0;
            ras_push_o   <= 1'b0;
            ras_pop_o    <= 1'b0;
            ras_addr_o   <= '0;
            ovf_o        <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            ras_push_o   <= 1'b0;
            ras_pop_o    <= 1'b0;
            pred_valid_o <= 1'b0;
            ovf_o        <= 1'b0;
            // depth_q already counts in-flight ops; the stack reports post-op flags to match
            if (state == IDLE && ((is_empty != ras_empty_i) || (is_full != ras_full_i)))
                err_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (req_type_i)
                            REQ_CALL: begin
                                if (!is_full) begin
                                    ras_push_o <= 1'b1;
                                    ras_addr_o <= req_link_i;
                                    depth_q    <= depth_q + CNT_W'(1);
                                end else begin
                                    ovf_o <= 1'b1;
                                end
                            end
                            REQ_RET, REQ_CORET: begin
                                if (!is_empty) begin
                                    pred_addr_o  <= ras_top_i;
                                    pred_valid_o <= 1'b1;
                                    ras_pop_o    <= 1'b1;
                                    depth_q      <= depth_q - CNT_W'(1);
                                end
                                if (req_type_i == REQ_CORET) begin
                                    link_q <= req_link_i;
                                    state  <= CORET_PUSH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CORET_PUSH: begin
                    if (!flush_i) begin
                        ras_push_o <= 1'b1;
                        ras_addr_o <= link_q;
                        depth_q    <= depth_q + CNT_W'(1);
                    end
                    state <= IDLE;
                end
                DRAIN: begin
                    if (!is_empty) begin
                        ras_pop_o <= 1'b1;
                        depth_q   <= depth_q - CNT_W'(1);
                    end
                    if (depth_q <= CNT_W'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (flush_i)
                state <= DRAIN;
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl driving a real ras; expectations come from a queue-based stack model.
module tb_ras_ctrl;
    import ras_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_type = 2'b00;
    logic [ADDR_W-1:0] req_link = '0;
    logic              flush = 1'b0;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_addr;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_addr;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic [CNT_W-1:0]  depth;
    logic              ovf;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] stk[$];

    always #5 clk_i = ~clk_i;

    ras_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_type_i(req_type), .req_link_i(req_link), .flush_i(flush),
        .pred_valid_o(pred_valid), .pred_addr_o(pred_addr), .ras_push_o(ras_push),
        .ras_pop_o(ras_pop), .ras_addr_o(ras_addr), .ras_top_i(ras_top),
        .ras_empty_i(ras_empty), .ras_full_i(ras_full), .depth_o(depth),
        .ovf_o(ovf), .busy_o(busy), .err_o(err)
    );

    ras #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ras (
        .clk_i(clk_i), .rst_i(rst_i), .ras_push_i(ras_push), .ras_pop_i(ras_pop),
        .ras_addr_i(ras_addr), .ras_addr_o(ras_top), .ras_empty_o(ras_empty), .ras_full_o(ras_full)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // offer one request for one cycle; returns in the cycle after the accepting edge
    task automatic send(input logic [1:0] t, input logic [ADDR_W-1:0] l);
        req_valid = 1'b1; req_type = t; req_link = l;
        tick();
        req_valid = 1'b0; req_type = 2'b00;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid: got %0b want 0", pred_valid); end
        checks++; if (pred_addr !== '0) begin errors++; $display("FAIL reset_pred_addr: got %0h want 0", pred_addr); end
        checks++; if (ras_push !== 1'b0 || ras_pop !== 1'b0) begin errors++; $display("FAIL reset_pulses: push %0b pop %0b want 0 0", ras_push, ras_pop); end
        checks++; if (ras_addr !== '0) begin errors++; $display("FAIL reset_ras_addr: got %0h want 0", ras_addr); end
        checks++; if (depth !== '0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
        checks++; if (ovf !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: ovf %0b busy %0b err %0b want 0 0 0", ovf, busy, err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
        rst_i = 1'b0;
        stk.delete();
        tick();
    endtask

    task automatic test_call_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            logic [ADDR_W-1:0] l;
            l = ADDR_W'((i + 1) * 'h100);
            send(REQ_CALL, l);
            stk.push_back(l);
            checks++; if (ras_push !== 1'b1 || ras_addr !== l) begin errors++; $display("FAIL call_push[%0d]: push %0b addr %0h want 1 %0h", i, ras_push, ras_addr, l); end
            checks++; if (depth !== CNT_W'(i + 1) || ovf !== 1'b0) begin errors++; $display("FAIL call_depth[%0d]: depth %0d ovf %0b want %0d 0", i, depth, ovf, i + 1); end
        end
        send(REQ_CALL, 64'h500);
        checks++; if (ovf !== 1'b1 || ras_push !== 1'b0) begin errors++; $display("FAIL call_ovf: ovf %0b push %0b want 1 0", ovf, ras_push); end
        checks++; if (depth !== CNT_W'(DEPTH)) begin errors++; $display("FAIL call_ovf_depth: got %0d want %0d", depth, DEPTH); end
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len: got %0b want 0", ovf); end
    endtask

    task automatic test_ret_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            logic [ADDR_W-1:0] e;
            e = stk.pop_back();
            send(REQ_RET, '0);
            checks++; if (pred_valid !== 1'b1 || pred_addr !== e) begin errors++; $display("FAIL ret_pred[%0d]: valid %0b addr %0h want 1 %0h", i, pred_valid, pred_addr, e); end
            checks++; if (ras_pop !== 1'b1 || depth !== CNT_W'(DEPTH - 1 - i)) begin errors++; $display("FAIL ret_pop[%0d]: pop %0b depth %0d want 1 %0d", i, ras_pop, depth, DEPTH - 1 - i); end
        end
        send(REQ_RET, '0);
        checks++; if (ras_pop !== 1'b0 || pred_valid !== 1'b0) begin errors++; $display("FAIL ret_underflow: pop %0b valid %0b want 0 0", ras_pop, pred_valid); end
        checks++; if (pred_addr !== 64'h100 || depth !== '0) begin errors++; $display("FAIL ret_hold: addr %0h depth %0d want 100 0", pred_addr, depth); end
    endtask

    task automatic test_coret();
        send(REQ_CALL, 64'h100);
        send(REQ_CORET, 64'h900);
        checks++; if (ras_pop !== 1'b1 || ras_push !== 1'b0 || pred_valid !== 1'b1 || pred_addr !== 64'h100) begin errors++; $display("FAIL coret_pop: pop %0b push %0b valid %0b addr %0h want 1 0 1 100", ras_pop, ras_push, pred_valid, pred_addr); end
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || depth !== '0) begin errors++; $display("FAIL coret_busy: busy %0b ready %0b depth %0d want 1 0 0", busy, req_ready, depth); end
        tick();
        checks++; if (ras_push !== 1'b1 || ras_pop !== 1'b0 || ras_addr !== 64'h900) begin errors++; $display("FAIL coret_push: push %0b pop %0b addr %0h want 1 0 900", ras_push, ras_pop, ras_addr); end
        checks++; if (depth !== CNT_W'(1) || busy !== 1'b0 || pred_valid !== 1'b0) begin errors++; $display("FAIL coret_after: depth %0d busy %0b valid %0b want 1 0 0", depth, busy, pred_valid); end
        send(REQ_RET, '0);
        checks++; if (pred_valid !== 1'b1 || pred_addr !== 64'h900 || depth !== '0) begin errors++; $display("FAIL coret_ret: valid %0b addr %0h depth %0d want 1 900 0", pred_valid, pred_addr, depth); end
        send(REQ_CORET, 64'hA00);
        checks++; if (ras_pop !== 1'b0 || pred_valid !== 1'b0) begin errors++; $display("FAIL coret_empty_pop: pop %0b valid %0b want 0 0", ras_pop, pred_valid); end
        tick();
        checks++; if (ras_push !== 1'b1 || ras_addr !== 64'hA00 || depth !== CNT_W'(1)) begin errors++; $display("FAIL coret_empty_push: push %0b addr %0h depth %0d want 1 a00 1", ras_push, ras_addr, depth); end
        send(REQ_RET, '0);
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) send(REQ_CALL, {$urandom, $urandom});
        tick();
        flush = 1'b1; req_valid = 1'b1; req_type = REQ_CALL; req_link = 64'hDEAD;
        tick();
        flush = 1'b0; req_valid = 1'b0; req_type = 2'b00;
        checks++; if (ras_push !== 1'b0 || ras_pop !== 1'b0 || depth !== CNT_W'(3)) begin errors++; $display("FAIL flush_blocks_req: push %0b pop %0b depth %0d want 0 0 3", ras_push, ras_pop, depth); end
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL flush_enter: busy %0b ready %0b want 1 0", busy, req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ras_pop !== 1'b1 || depth !== CNT_W'(2 - k)) begin errors++; $display("FAIL drain_pop[%0d]: pop %0b depth %0d want 1 %0d", k, ras_pop, depth, 2 - k); end
            checks++; if (busy !== (k < 2) || req_ready !== (k == 2)) begin errors++; $display("FAIL drain_busy[%0d]: busy %0b ready %0b want %0b %0b", k, busy, req_ready, k < 2, k == 2); end
        end
        tick();
        checks++; if (ras_pop !== 1'b0 || ras_empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL drain_done: pop %0b empty %0b err %0b want 0 1 0", ras_pop, ras_empty, err); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (busy !== 1'b1 || ras_pop !== 1'b0) begin errors++; $display("FAIL flush_empty_enter: busy %0b pop %0b want 1 0", busy, ras_pop); end
        tick();
        checks++; if (busy !== 1'b0 || ras_pop !== 1'b0) begin errors++; $display("FAIL flush_empty_exit: busy %0b pop %0b want 0 0", busy, ras_pop); end
    endtask

    task automatic test_flush_coret_push();
        send(REQ_CALL, 64'h11);
        send(REQ_CALL, 64'h22);
        send(REQ_CORET, 64'h33);
        checks++; if (pred_addr !== 64'h22 || ras_pop !== 1'b1) begin errors++; $display("FAIL fcp_pop: addr %0h pop %0b want 22 1", pred_addr, ras_pop); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (ras_push !== 1'b0 || busy !== 1'b1 || depth !== CNT_W'(1)) begin errors++; $display("FAIL fcp_no_push: push %0b busy %0b depth %0d want 0 1 1", ras_push, busy, depth); end
        tick();
        checks++; if (ras_pop !== 1'b1 || depth !== '0 || busy !== 1'b0) begin errors++; $display("FAIL fcp_drain: pop %0b depth %0d busy %0b want 1 0 0", ras_pop, depth, busy); end
        tick();
        checks++; if (ras_empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL fcp_end: empty %0b err %0b want 1 0", ras_empty, err); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) send(REQ_CALL, {$urandom, $urandom});
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        checks++; if (ras_pop !== 1'b0 || ras_push !== 1'b0 || busy !== 1'b0 || depth !== '0) begin errors++; $display("FAIL rst_mid_drain: pop %0b push %0b busy %0b depth %0d want 0 0 0 0", ras_pop, ras_push, busy, depth); end
        tick();
        rst_i = 1'b0;
        stk.delete();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                int exp_pops;
                int pops;
                int cyc;
                exp_pops = stk.size(); pops = 0; cyc = 0;
                flush = 1'b1; tick(); flush = 1'b0;
                while (busy === 1'b1 && cyc < 12) begin
                    tick(); cyc++;
                    if (ras_pop === 1'b1) pops++;
                end
                checks++; if (cyc >= 12 || pops != exp_pops) begin errors++; $display("FAIL rnd_flush[%0d]: pops %0d cycles %0d want %0d pops", n, pops, cyc, exp_pops); end
                stk.delete();
            end else if (r < 4) begin
                tick();
            end else begin
                logic [1:0] t;
                logic [ADDR_W-1:0] l;
                t = 2'($urandom_range(0, 3));
                l = {$urandom, $urandom};
                send(t, l);
                if (t == REQ_CALL) begin
                    if (stk.size() < DEPTH) begin
                        stk.push_back(l);
                        checks++; if (ras_push !== 1'b1 || ras_addr !== l || ovf !== 1'b0) begin errors++; $display("FAIL rnd_call[%0d]: push %0b addr %0h ovf %0b want 1 %0h 0", n, ras_push, ras_addr, ovf, l); end
                    end else begin
                        checks++; if (ras_push !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL rnd_ovf[%0d]: push %0b ovf %0b want 0 1", n, ras_push, ovf); end
                    end
                end else if (t == REQ_RET || t == REQ_CORET) begin
                    if (stk.size() > 0) begin
                        logic [ADDR_W-1:0] e;
                        e = stk.pop_back();
                        checks++; if (pred_valid !== 1'b1 || pred_addr !== e || ras_pop !== 1'b1) begin errors++; $display("FAIL rnd_ret[%0d]: valid %0b addr %0h pop %0b want 1 %0h 1", n, pred_valid, pred_addr, ras_pop, e); end
                    end else begin
                        checks++; if (pred_valid !== 1'b0 || ras_pop !== 1'b0) begin errors++; $display("FAIL rnd_unf[%0d]: valid %0b pop %0b want 0 0", n, pred_valid, ras_pop); end
                    end
                    if (t == REQ_CORET) begin
                        tick();
                        stk.push_back(l);
                        checks++; if (ras_push !== 1'b1 || ras_addr !== l || ras_pop !== 1'b0) begin errors++; $display("FAIL rnd_coret_push[%0d]: push %0b addr %0h pop %0b want 1 %0h 0", n, ras_push, ras_addr, ras_pop, l); end
                    end
                end else begin
                    checks++; if (ras_push !== 1'b0 || ras_pop !== 1'b0 || pred_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rnd_illegal[%0d]: push %0b pop %0b valid %0b ovf %0b want 0 0 0 0", n, ras_push, ras_pop, pred_valid, ovf); end
                end
                checks++; if (depth !== CNT_W'(stk.size())) begin errors++; $display("FAIL rnd_depth[%0d]: got %0d want %0d", n, depth, stk.size()); end
            end
        end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %0b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_call_overflow();
        test_ret_underflow();
        test_coret();
        test_flush();
        test_flush_coret_push();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
